// File: rtl/alu_src_stage.sv
// ALU operand-B source select with EX/MEM and MEM/WB forwarding, registered
// into the ID/EX boundary with stall/flush control.
module alu_src_stage #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16,
  parameter int REG_ADDR  = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [1:0]           ALUsrc,
  input  logic [WIDTH-1:0]     ReadData2,
  input  logic [IMM_WIDTH-1:0] Imm,
  input  logic [REG_ADDR-1:0]  Rt,
  input  logic                 ExMemRegWrite,
  input  logic [REG_ADDR-1:0]  ExMemRd,
  input  logic [WIDTH-1:0]     ExMemResult,
  input  logic                 MemWbRegWrite,
  input  logic [REG_ADDR-1:0]  MemWbRd,
  input  logic [WIDTH-1:0]     MemWbResult,
  output logic [WIDTH-1:0]     ALUin2,
  output logic                 out_valid,
  output logic [1:0]           fwd_sel
);

  localparam logic [1:0] SRC_REG  = 2'b00;
  localparam logic [1:0] SRC_SEXT = 2'b01;
  localparam logic [1:0] SRC_ZEXT = 2'b10;
  localparam logic [1:0] SRC_SHMT = 2'b11;

  localparam logic [1:0] FWD_NONE  = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  function automatic logic signed [WIDTH-1:0] sign_ext(input logic [IMM_WIDTH-1:0] imm);
    logic signed [IMM_WIDTH-1:0] s;
    s = $signed(imm);
    return WIDTH'(s);
  endfunction

  function automatic logic [WIDTH-1:0] zero_ext(input logic [IMM_WIDTH-1:0] imm);
    return WIDTH'(imm);
  endfunction

  function automatic logic [WIDTH-1:0] shamt_ext(input logic [IMM_WIDTH-1:0] imm);
    logic [4:0] sh;
    sh = imm[10:6];
    return WIDTH'(sh);
  endfunction

  // Register index 0 is hard-wired zero, so a write to it never forwards.
  function automatic logic fwd_hit(input logic                we,
                                   input logic [REG_ADDR-1:0] rd,
                                   input logic [REG_ADDR-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

  // Stage p0: combinational operand selection and forwarding decision
  logic             ex_hit_p0;
  logic             mw_hit_p0;
  logic [WIDTH-1:0] sel_val_p0;
  logic [1:0]       sel_fwd_p0;

  assign ex_hit_p0 = fwd_hit(ExMemRegWrite, ExMemRd, Rt);
  assign mw_hit_p0 = fwd_hit(MemWbRegWrite, MemWbRd, Rt);

  always_comb begin
    sel_val_p0 = ReadData2;
    sel_fwd_p0 = FWD_NONE;
    case (ALUsrc)
      SRC_REG: begin
        if (ex_hit_p0) begin
          sel_val_p0 = ExMemResult;
          sel_fwd_p0 = FWD_EXMEM;
        end else if (mw_hit_p0) begin
          sel_val_p0 = MemWbResult;
          sel_fwd_p0 = FWD_MEMWB;
        end
      end
      SRC_SEXT: sel_val_p0 = sign_ext(Imm);
      SRC_ZEXT: sel_val_p0 = zero_ext(Imm);
      SRC_SHMT: sel_val_p0 = shamt_ext(Imm);
      default:  sel_val_p0 = ReadData2;
    endcase
  end

  // Stage p1: ID/EX boundary registers
  logic [WIDTH-1:0] alu_p1;
  logic [1:0]       fwd_p1;
  logic             vld_p1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_p1 <= '0;
      fwd_p1 <= FWD_NONE;
      vld_p1 <= 1'b0;
    end else if (flush) begin
      alu_p1 <= '0;
      fwd_p1 <= FWD_NONE;
      vld_p1 <= 1'b0;
    end else if (!stall) begin
      if (!in_valid) begin
        alu_p1 <= '0;
        fwd_p1 <= FWD_NONE;
        vld_p1 <= 1'b0;
      end else begin
        alu_p1 <= sel_val_p0;
        fwd_p1 <= sel_fwd_p0;
        vld_p1 <= 1'b1;
      end
    end
  end

  assign ALUin2    = alu_p1;
  assign fwd_sel   = fwd_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_alu_src_stage.sv
// Self-checking bench for alu_src_stage: directed cases plus randomized
// traffic compared against a behavioural model of the operand-B stage.
module tb_alu_src_stage;

  localparam int W  = 32;
  localparam int IW = 16;
  localparam int RA = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          stall, flush, in_valid;
  logic [1:0]    ALUsrc;
  logic [W-1:0]  ReadData2;
  logic [IW-1:0] Imm;
  logic [RA-1:0] Rt;
  logic          ExMemRegWrite;
  logic [RA-1:0] ExMemRd;
  logic [W-1:0]  ExMemResult;
  logic          MemWbRegWrite;
  logic [RA-1:0] MemWbRd;
  logic [W-1:0]  MemWbResult;
  logic [W-1:0]  ALUin2;
  logic          out_valid;
  logic [1:0]    fwd_sel;

  alu_src_stage #(.WIDTH(W), .IMM_WIDTH(IW), .REG_ADDR(RA)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .ALUsrc(ALUsrc), .ReadData2(ReadData2), .Imm(Imm),
    .Rt(Rt), .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd),
    .ExMemResult(ExMemResult), .MemWbRegWrite(MemWbRegWrite),
    .MemWbRd(MemWbRd), .MemWbResult(MemWbResult), .ALUin2(ALUin2),
    .out_valid(out_valid), .fwd_sel(fwd_sel)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Behavioural model state: what the output registers should hold.
  logic [W-1:0] m_alu;
  logic [1:0]   m_fwd;
  logic         m_vld;

  function automatic logic [W-1:0] ref_operand(output logic [1:0] src);
    longint v;
    src = 2'd0;
    if (ALUsrc == 2'd1) begin
      v = longint'(Imm);
      if (Imm >= (1 << (IW - 1))) v = v - (longint'(1) << IW);
      return v[W-1:0];
    end
    if (ALUsrc == 2'd2) return W'(Imm);
    if (ALUsrc == 2'd3) return W'((Imm / 64) % 32);
    if (ExMemRegWrite && ExMemRd != 0 && ExMemRd == Rt) begin
      src = 2'd1;
      return ExMemResult;
    end
    if (MemWbRegWrite && MemWbRd != 0 && MemWbRd == Rt) begin
      src = 2'd2;
      return MemWbResult;
    end
    return ReadData2;
  endfunction

  task automatic model_edge();
    logic [1:0] s;
    logic [W-1:0] v;
    v = ref_operand(s);
    if (reset || flush || (!stall && !in_valid)) begin
      m_alu = '0; m_fwd = 2'd0; m_vld = 1'b0;
    end else if (!stall) begin
      m_alu = v; m_fwd = s; m_vld = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_alu"}, 64'(ALUin2), 64'(m_alu));
    chk({tag, "_vld"}, 64'(out_valid), 64'(m_vld));
    chk({tag, "_fwd"}, 64'(fwd_sel), 64'(m_fwd));
  endtask

  // Apply one clock edge with the currently driven inputs, then compare.
  task automatic step(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; in_valid = 0; ALUsrc = 0; ReadData2 = 0; Imm = 0; Rt = 0;
    ExMemRegWrite = 0; ExMemRd = 0; ExMemResult = 0;
    MemWbRegWrite = 0; MemWbRd = 0; MemWbResult = 0;
  endtask

  initial begin
    // Reset with every input nonzero
    reset = 1; stall = 0; flush = 1; in_valid = 1; ALUsrc = 2'd1;
    ReadData2 = 32'hDEADBEEF; Imm = 16'hFFFF; Rt = 5'd7;
    ExMemRegWrite = 1; ExMemRd = 5'd7; ExMemResult = 32'h1;
    MemWbRegWrite = 1; MemWbRd = 5'd7; MemWbResult = 32'h2;
    m_alu = '0; m_fwd = 0; m_vld = 0;
    #3;
    check_all("rst_async");
    flush = 0;
    repeat (2) begin
      @(posedge clock); #1;
      check_all("rst_hold");
    end
    idle_inputs();
    reset = 0;
    step("rel_idle");
    step("rel_idle2");

    // Immediate extensions
    in_valid = 1; ALUsrc = 2'd1; Imm = 16'h8001;
    step("sext");
    chk("sext_lit", 64'(ALUin2), 64'h0000_0000_FFFF_8001);
    ALUsrc = 2'd2;
    step("zext");
    chk("zext_lit", 64'(ALUin2), 64'h8001);
    ALUsrc = 2'd3; Imm = 16'h07C0;
    step("shamt");
    chk("shamt_lit", 64'(ALUin2), 64'h1F);

    // Forwarding priority
    ALUsrc = 2'd0; Rt = 5'd5; ReadData2 = 32'h11;
    ExMemRegWrite = 1; ExMemRd = 5'd5; ExMemResult = 32'hAA;
    MemWbRegWrite = 1; MemWbRd = 5'd5; MemWbResult = 32'hBB;
    step("fwd_ex");
    chk("fwd_ex_lit", 64'(ALUin2), 64'hAA);
    chk("fwd_ex_sel", 64'(fwd_sel), 64'd1);
    ExMemRegWrite = 0;
    step("fwd_mw");
    chk("fwd_mw_lit", 64'(ALUin2), 64'hBB);
    chk("fwd_mw_sel", 64'(fwd_sel), 64'd2);

    // Register 0 never forwards; immediates ignore hits
    Rt = 0; ReadData2 = 0; ExMemRegWrite = 1; ExMemRd = 0; MemWbRd = 0;
    step("r0");
    chk("r0_sel", 64'(fwd_sel), 64'd0);
    Rt = 5'd9; ExMemRd = 5'd9; ALUsrc = 2'd1; Imm = 16'h0042;
    step("imm_hit");
    chk("imm_hit_lit", 64'(ALUin2), 64'h42);

    // Stall holds, flush overrides stall
    idle_inputs(); in_valid = 1; ReadData2 = 32'h1234;
    step("load");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      ReadData2 = $urandom; Imm = 16'($urandom); ALUsrc = 2'($urandom); in_valid = 1'($urandom);
      step("stall");
      chk("stall_lit", 64'(ALUin2), 64'h1234);
    end
    flush = 1;
    step("stall_flush");
    chk("flush_lit", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges
    idle_inputs(); in_valid = 1; ReadData2 = 32'h5A5A;
    step("pre_rst");
    #3 reset = 1;
    m_alu = '0; m_fwd = 0; m_vld = 0;
    #1 check_all("mid_rst");
    @(negedge clock);
    reset = 0;
    step("post_rst");
    chk("post_rst_lit", 64'(ALUin2), 64'h5A5A);

    // Randomized traffic with small register range to provoke hits
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      in_valid = ($urandom_range(0, 4) != 0);
      ALUsrc = 2'($urandom);
      ReadData2 = $urandom; Imm = 16'($urandom);
      Rt = 5'($urandom_range(0, 3));
      ExMemRegWrite = 1'($urandom); ExMemRd = 5'($urandom_range(0, 3)); ExMemResult = $urandom;
      MemWbRegWrite = 1'($urandom); MemWbRd = 5'($urandom_range(0, 3)); MemWbResult = $urandom;
      if (i % 97 == 50) begin
        reset = 1;
        #1;
        m_alu = '0; m_fwd = 0; m_vld = 0;
        check_all("rnd_rst");
        @(negedge clock);
        reset = 0;
      end
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_src_stage.md
Name: alu_src_stage

Overview:
- Registered, parametrised successor to the single-bit ALU operand-B select in the MIPS datapath.
- Selects operand B from four sources: register data, sign-extended immediate, zero-extended immediate, or shift amount.
- Applies EX/MEM and MEM/WB forwarding to the register source.
- Registers the result into the ID/EX boundary, with stall and flush control. Output feeds the ALU second input one cycle later.

Parameters:
- WIDTH, 32, datapath width of operand and forwarded results (must be >= IMM_WIDTH)
- IMM_WIDTH, 16, immediate field width (must be >= 11 so the shamt field exists)
- REG_ADDR, 5, register-index width

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hold all output registers
- flush  input  1  insert bubble on next edge
- in_valid  input  1  decode stage presents a valid instruction
- ALUsrc  input  2  00 ReadData2, 01 sign-ext Imm, 10 zero-ext Imm, 11 shamt
- ReadData2  input  WIDTH  register-file read data for operand B
- Imm  input  IMM_WIDTH  instruction immediate field
- Rt  input  REG_ADDR  register index that ReadData2 was read from
- ExMemRegWrite  input  1  EX/MEM stage writes a register
- ExMemRd  input  REG_ADDR  EX/MEM destination index
- ExMemResult  input  WIDTH  EX/MEM ALU result
- MemWbRegWrite  input  1  MEM/WB stage writes a register
- MemWbRd  input  REG_ADDR  MEM/WB destination index
- MemWbResult  input  WIDTH  MEM/WB write-back data
- ALUin2  output  WIDTH  registered ALU operand B
- out_valid  output  1  ALUin2 carries a valid instruction
- fwd_sel  output  2  registered forwarding source: 0 none, 1 EX/MEM, 2 MEM/WB; value 3 is never driven

Behaviour:
- Reset (asynchronous, active-high): ALUin2=0, out_valid=0, fwd_sel=0, immediately and for as long as reset is high.
- Combinational selection, formed each cycle:
  - sign-ext = Imm replicated MSB to WIDTH.
  - zero-ext = Imm padded with zeros.
  - shamt = Imm[10:6] zero-extended to WIDTH.
- Forwarding applies only when ALUsrc=00:
  - EX/MEM hit = ExMemRegWrite & ExMemRd!=0 & ExMemRd==Rt.
  - MEM/WB hit = MemWbRegWrite & MemWbRd!=0 & MemWbRd==Rt.
  - EX/MEM has priority over MEM/WB.
  - With no hit, ReadData2 is used.
  - For ALUsrc!=00 the selected fwd value is 0 regardless of hits.
- Register update on rising clock edge, in priority order:
  1. flush=1: out_valid<=0, ALUin2<=0, fwd_sel<=0. Flush overrides stall.
  2. stall=1: all outputs hold their current values; inputs are ignored.
  3. in_valid=0: out_valid<=0, ALUin2<=0, fwd_sel<=0.
  4. Otherwise: ALUin2<=selected value, fwd_sel<=forward source, out_valid<=1.
- Latency: exactly 1 clock from inputs to ALUin2. No combinational path from inputs to outputs.
- Register index 0 never forwards, even if RegWrite is asserted with Rd=0.
- Both stages hitting the same Rt: EX/MEM result is used.
- Reset asserted mid-stall or mid-flush: outputs clear immediately. The first edge after reset deassertion follows the normal rules.
- No arithmetic beyond extension; no overflow cases.

Test Plan:
- Reset with all inputs nonzero, then release, in_valid=0 -> ALUin2=0, out_valid=0, fwd_sel=0 throughout.
- ALUsrc=01, Imm=16'h8001, in_valid=1 -> next cycle ALUin2=32'hFFFF8001, out_valid=1. ALUsrc=10 same Imm -> ALUin2=32'h00008001. ALUsrc=11, Imm=16'h07C0 -> ALUin2=32'h1F.
- ALUsrc=00, Rt=5, ReadData2=32'h11, ExMemRegWrite=1, ExMemRd=5, ExMemResult=32'hAA, MemWbRegWrite=1, MemWbRd=5, MemWbResult=32'hBB -> ALUin2=32'hAA, fwd_sel=1. Then deassert ExMemRegWrite -> ALUin2=32'hBB, fwd_sel=2.
- Rt=0 with both stages writing Rd=0, ReadData2=32'h0 -> ALUin2=0, fwd_sel=0. ALUsrc=01 with an EX/MEM hit -> immediate used, fwd_sel=0.
- Load 32'h1234, then stall=1 for 3 cycles with changing inputs -> ALUin2 stays 32'h1234, out_valid=1. Then stall=1 and flush=1 together -> ALUin2=0, out_valid=0.
- Assert reset asynchronously between clock edges while out_valid=1 -> outputs clear before the next edge. After release with valid inputs, loading resumes one cycle later.
